// File: rtl/tetris_pkg.sv
// Shared constants, command encoding and board type for the Tetris playfield.
package tetris_pkg;

  localparam int ROWS        = 22;
  localparam int COLS        = 10;
  localparam int SPAWN_COL   = 3;
  localparam int HIDDEN_ROWS = 2;

  typedef enum logic [2:0] {
    CMD_CHECK = 3'b000,
    CMD_MOVE  = 3'b001,
    CMD_WRITE = 3'b010,
    CMD_SHIFT = 3'b011,
    CMD_ADD   = 3'b100
  } cmd_e;

  // Row r, bit c is the cell at (r, c); row 0 is the top.
  typedef logic [ROWS-1:0][COLS-1:0] board_t;

endpackage

// File: rtl/piece_fit.sv
// Combinational test of whether a 4x4 piece mask fits on the board at (row, col).
module piece_fit #(
  parameter int ROWS = 22,
  parameter int COLS = 10
) (
  input  logic [ROWS-1:0][COLS-1:0] board,
  input  logic [15:0]               mask,
  input  logic [4:0]                row,
  input  logic signed [4:0]         col,
  output logic                      fits
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  always_comb begin
    int rr;
    int cc;
    fits = 1'b1;
    rr   = 0;
    cc   = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        rr = int'(row) + r;
        cc = int'(col) + c;
        if (mask[4*r+c]) begin
          if (rr >= ROWS || cc < 0 || cc >= COLS) begin
            fits = 1'b0;
          end else if (board[rr[RW-1:0]][cc[CW-1:0]]) begin
            fits = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/board_datapath.sv
// Playfield datapath: holds the board and active piece, executes controller
// commands on a change of cmd code, and reports full rows, landing and game over.
module board_datapath #(
  parameter int ROWS      = tetris_pkg::ROWS,
  parameter int COLS      = tetris_pkg::COLS,
  parameter int SPAWN_COL = tetris_pkg::SPAWN_COL
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      cmd,
  input  logic [15:0]     piece_mask,
  input  logic            move_left,
  input  logic            move_right,
  input  logic [4:0]      rd_row,
  output logic [ROWS-1:0] shift,
  output logic [ROWS-1:0] stop,
  output logic [1:0]      game_over,
  output logic            piece_ack,
  output logic [COLS-1:0] rd_data
);

  import tetris_pkg::*;

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic signed [4:0] SPAWN_C = 5'(SPAWN_COL);

  typedef logic [ROWS-1:0][COLS-1:0] brd_t;

  brd_t              board;
  logic [15:0]       mask_q;
  logic [4:0]        prow;
  logic signed [4:0] pcol;
  logic              piece_valid;
  logic [2:0]        cmd_q;
  logic              pend_l;
  logic              pend_r;

  cmd_e              cmd_c;
  logic              exec;
  logic signed [4:0] dc;
  logic signed [4:0] col_try;
  logic signed [4:0] col_lat;
  logic [4:0]        row_down;
  logic              lat_fits;
  logic              drop_fits;
  logic              spawn_fits;
  brd_t              piece_map;
  brd_t              shifted;
  logic              hidden_hit;
  logic [ROWS-1:0]   full;

  assign cmd_c = cmd_e'(cmd);
  // Edge-triggered: a held code runs once; a frozen game runs nothing.
  assign exec  = (cmd != cmd_q) && (game_over == 2'b00);

  always_comb begin
    dc = 5'sd0;
    if (pend_l && !pend_r) dc = -5'sd1;
    else if (pend_r && !pend_l) dc = 5'sd1;
  end

  assign col_try  = pcol + dc;
  assign col_lat  = lat_fits ? col_try : pcol;
  assign row_down = prow + 5'd1;

  piece_fit #(.ROWS(ROWS), .COLS(COLS)) u_fit_lateral (
    .board (board),
    .mask  (mask_q),
    .row   (prow),
    .col   (col_try),
    .fits  (lat_fits)
  );

  // Drop is tested from the column the lateral step settled on.
  piece_fit #(.ROWS(ROWS), .COLS(COLS)) u_fit_drop (
    .board (board),
    .mask  (mask_q),
    .row   (row_down),
    .col   (col_lat),
    .fits  (drop_fits)
  );

  piece_fit #(.ROWS(ROWS), .COLS(COLS)) u_fit_spawn (
    .board (board),
    .mask  (piece_mask),
    .row   (5'd0),
    .col   (SPAWN_C),
    .fits  (spawn_fits)
  );

  always_comb begin
    int rr;
    int cc;
    piece_map = '0;
    rr        = 0;
    cc        = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        rr = int'(prow) + r;
        cc = int'(pcol) + c;
        if (piece_valid && mask_q[4*r+c] && rr < ROWS && cc >= 0 && cc < COLS) begin
          piece_map[rr[RW-1:0]][cc[CW-1:0]] = 1'b1;
        end
      end
    end
  end

  assign hidden_hit = |piece_map[HIDDEN_ROWS-1:0];

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      full[r] = &board[r];
    end
  end

  assign shift = full;

  // Remove only the lowest full row; everything above it slides down one.
  always_comb begin
    int top_full;
    top_full = 0;
    for (int r = 0; r < ROWS; r++) begin
      if (full[r]) top_full = r;
    end
    shifted = board;
    for (int r = 0; r < ROWS; r++) begin
      if (r <= top_full) begin
        if (r == 0) shifted[r] = '0;
        else        shifted[r] = board[r-1];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (int'(rd_row) < ROWS) begin
      rd_data = board[rd_row[RW-1:0]] | piece_map[rd_row[RW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      board       <= '0;
      mask_q      <= '0;
      prow        <= '0;
      pcol        <= SPAWN_C;
      piece_valid <= 1'b0;
      cmd_q       <= CMD_CHECK;
      pend_l      <= 1'b0;
      pend_r      <= 1'b0;
      stop        <= '0;
      game_over   <= 2'b00;
      piece_ack   <= 1'b0;
    end else begin
      cmd_q     <= cmd;
      piece_ack <= 1'b0;
      pend_l    <= pend_l | move_left;
      pend_r    <= pend_r | move_right;
      if (exec) begin
        case (cmd_c)
          CMD_ADD: begin
            mask_q      <= piece_mask;
            prow        <= '0;
            pcol        <= SPAWN_C;
            piece_valid <= 1'b1;
            stop        <= '0;
            piece_ack   <= 1'b1;
            if (!spawn_fits) game_over[0] <= 1'b1;
          end
          CMD_MOVE: begin
            if (piece_valid) begin
              pcol <= col_lat;
              if (drop_fits && prow != 5'h1f) prow <= row_down;
              else stop <= {{(ROWS-1){1'b0}}, 1'b1} << prow;
              // A request arriving on this very cycle is kept for the next MOVE.
              pend_l <= move_left;
              pend_r <= move_right;
            end
          end
          CMD_WRITE: begin
            if (piece_valid) begin
              board       <= board | piece_map;
              piece_valid <= 1'b0;
              if (hidden_hit) game_over[1] <= 1'b1;
            end
          end
          CMD_SHIFT: begin
            if (|full) board <= shifted;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_board_datapath.sv
// Scoreboard bench for board_datapath: stimulus queues expected values, a
// monitor pops and compares them on the falling edge after each command.
`timescale 1ns/100ps
module tb_board_datapath;
  import tetris_pkg::*;

  localparam int K_RD    = 0;
  localparam int K_SHIFT = 1;
  localparam int K_STOP  = 2;
  localparam int K_GO    = 3;
  localparam int K_ACK   = 4;

  typedef struct {
    string       name;
    int          kind;
    int          row;
    logic [21:0] val;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  logic        clk;
  logic        reset;
  logic [2:0]  cmd;
  logic [15:0] piece_mask;
  logic        move_left;
  logic        move_right;
  logic [4:0]  rd_row;
  logic [21:0] shift;
  logic [21:0] stop;
  logic [1:0]  game_over;
  logic        piece_ack;
  logic [9:0]  rd_data;

  board_datapath dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd),
    .piece_mask (piece_mask),
    .move_left  (move_left),
    .move_right (move_right),
    .rd_row     (rd_row),
    .shift      (shift),
    .stop       (stop),
    .game_over  (game_over),
    .piece_ack  (piece_ack),
    .rd_data    (rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: only process that drives rd_row.
  initial begin
    exp_t        e;
    logic [21:0] act;
    rd_row = 5'd0;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e      = q.pop_front();
        rd_row = 5'(e.row);
        #0.1;
        case (e.kind)
          K_RD:    act = 22'(rd_data);
          K_SHIFT: act = shift;
          K_STOP:  act = stop;
          K_GO:    act = 22'(game_over);
          default: act = 22'(piece_ack);
        endcase
        checks++;
        if (act !== e.val) begin
          failures++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.val);
        end
      end
    end
  end

  task automatic expect_v(input string n, input int k, input int r, input logic [21:0] v);
    exp_t e;
    e.name = n;
    e.kind = k;
    e.row  = r;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exec(input logic [2:0] c);
    cmd = c;
    tick();
    cmd = CMD_CHECK;
    tick();
  endtask

  task automatic pulse(input logic l, input logic r);
    move_left  = l;
    move_right = r;
    tick();
    move_left  = 1'b0;
    move_right = 1'b0;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    cmd        = CMD_CHECK;
    move_left  = 1'b0;
    move_right = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic drop_piece(input logic [15:0] m, input int dx, input int nmoves);
    int adx;
    adx = (dx < 0) ? -dx : dx;
    piece_mask = m;
    exec(CMD_ADD);
    for (int i = 0; i < nmoves; i++) begin
      if (i < adx) pulse(dx < 0, dx > 0);
      exec(CMD_MOVE);
    end
    exec(CMD_WRITE);
  endtask

  initial begin
    reset      = 1'b1;
    cmd        = CMD_CHECK;
    piece_mask = 16'h0000;
    move_left  = 1'b0;
    move_right = 1'b0;

    // Reset state and spawn of an O piece
    do_reset();
    expect_v("rst_rd0", K_RD, 0, 22'h0);
    expect_v("rst_shift", K_SHIFT, 0, 22'h0);
    expect_v("rst_stop", K_STOP, 0, 22'h0);
    expect_v("rst_go", K_GO, 0, 22'h0);
    expect_v("rst_ack", K_ACK, 0, 22'h0);
    piece_mask = 16'h0033;
    cmd = CMD_ADD;
    tick();
    expect_v("add_ack", K_ACK, 0, 22'h1);
    expect_v("add_rd0", K_RD, 0, 22'h018);
    expect_v("add_rd1", K_RD, 1, 22'h018);
    expect_v("add_stop", K_STOP, 0, 22'h0);
    expect_v("add_go", K_GO, 0, 22'h0);
    cmd = CMD_CHECK;
    tick();
    expect_v("add_ack_drop", K_ACK, 0, 22'h0);

    // Drop to the floor
    exec(CMD_MOVE);
    expect_v("mv1_rd0", K_RD, 0, 22'h0);
    expect_v("mv1_rd2", K_RD, 2, 22'h018);
    repeat (19) exec(CMD_MOVE);
    expect_v("mv20_rd20", K_RD, 20, 22'h018);
    expect_v("mv20_rd21", K_RD, 21, 22'h018);
    expect_v("mv20_rd19", K_RD, 19, 22'h0);
    expect_v("mv20_stop", K_STOP, 0, 22'h0);
    exec(CMD_MOVE);
    expect_v("mv21_stop", K_STOP, 0, 22'h100000);
    expect_v("mv21_rd20", K_RD, 20, 22'h018);
    expect_v("mv21_rd19", K_RD, 19, 22'h0);
    expect_v("rd_row22", K_RD, 22, 22'h0);
    expect_v("rd_row31", K_RD, 31, 22'h0);

    // Fill rows 20-21 and shift them out
    do_reset();
    drop_piece(16'h0033, -3, 21);
    drop_piece(16'h0033, -1, 21);
    drop_piece(16'h0033, 3, 21);
    drop_piece(16'h0033, 5, 21);
    expect_v("prefill_shift", K_SHIFT, 0, 22'h0);
    expect_v("prefill_rd21", K_RD, 21, 22'h3CF);
    drop_piece(16'h0033, 1, 21);
    expect_v("full_shift", K_SHIFT, 0, 22'h300000);
    expect_v("full_rd20", K_RD, 20, 22'h3FF);
    expect_v("full_rd21", K_RD, 21, 22'h3FF);
    expect_v("full_rd22", K_RD, 22, 22'h0);
    exec(CMD_SHIFT);
    expect_v("sh1_shift", K_SHIFT, 0, 22'h200000);
    expect_v("sh1_rd21", K_RD, 21, 22'h3FF);
    expect_v("sh1_rd20", K_RD, 20, 22'h0);
    exec(CMD_SHIFT);
    expect_v("sh2_shift", K_SHIFT, 0, 22'h0);
    expect_v("sh2_rd21", K_RD, 21, 22'h0);

    // Lateral moves, wall block, simultaneous requests, late request
    do_reset();
    piece_mask = 16'h000F;
    exec(CMD_ADD);
    expect_v("i_spawn_rd0", K_RD, 0, 22'h078);
    repeat (3) begin
      pulse(1'b1, 1'b0);
      exec(CMD_MOVE);
    end
    expect_v("i_left3_rd3", K_RD, 3, 22'h00F);
    repeat (5) pulse(1'b1, 1'b0);
    exec(CMD_MOVE);
    expect_v("i_wall_rd4", K_RD, 4, 22'h00F);
    expect_v("i_wall_rd3", K_RD, 3, 22'h0);
    pulse(1'b1, 1'b1);
    exec(CMD_MOVE);
    expect_v("i_both_rd5", K_RD, 5, 22'h00F);
    pulse(1'b0, 1'b1);
    exec(CMD_MOVE);
    expect_v("i_right_rd6", K_RD, 6, 22'h01E);
    cmd = CMD_MOVE;
    move_right = 1'b1;
    tick();
    move_right = 1'b0;
    cmd = CMD_CHECK;
    tick();
    expect_v("i_late_rd7", K_RD, 7, 22'h01E);
    exec(CMD_MOVE);
    expect_v("i_kept_rd8", K_RD, 8, 22'h03C);

    // Spawn overlap freezes the game
    do_reset();
    repeat (10) drop_piece(16'h0033, 0, 21);
    expect_v("stack_rd2", K_RD, 2, 22'h018);
    expect_v("stack_rd1", K_RD, 1, 22'h0);
    expect_v("stack_go", K_GO, 0, 22'h0);
    piece_mask = 16'h3300;
    cmd = CMD_ADD;
    tick();
    expect_v("ovl_ack", K_ACK, 0, 22'h1);
    expect_v("ovl_go", K_GO, 0, 22'h1);
    cmd = CMD_CHECK;
    tick();
    exec(CMD_MOVE);
    expect_v("frozen_stop", K_STOP, 0, 22'h0);
    piece_mask = 16'h000F;
    cmd = CMD_ADD;
    tick();
    expect_v("frozen_ack", K_ACK, 0, 22'h0);
    cmd = CMD_CHECK;
    tick();
    expect_v("frozen_rd0", K_RD, 0, 22'h0);
    exec(CMD_WRITE);
    exec(CMD_SHIFT);
    expect_v("frozen_go", K_GO, 0, 22'h1);
    expect_v("frozen_rd3", K_RD, 3, 22'h018);

    // Lock in a hidden row
    do_reset();
    piece_mask = 16'h0033;
    exec(CMD_ADD);
    exec(CMD_MOVE);
    exec(CMD_WRITE);
    expect_v("hid_go", K_GO, 0, 22'h2);
    expect_v("hid_rd1", K_RD, 1, 22'h018);
    expect_v("hid_rd2", K_RD, 2, 22'h018);
    exec(CMD_ADD);
    expect_v("hid_frozen_rd0", K_RD, 0, 22'h0);

    // Held codes execute once; unused code ignored
    do_reset();
    piece_mask = 16'h0033;
    cmd = CMD_ADD;
    tick();
    expect_v("hold_ack1", K_ACK, 0, 22'h1);
    tick();
    expect_v("hold_ack2", K_ACK, 0, 22'h0);
    cmd = CMD_MOVE;
    tick();
    expect_v("hold_mv_ack", K_ACK, 0, 22'h0);
    expect_v("hold_mv_rd1", K_RD, 1, 22'h018);
    tick();
    tick();
    expect_v("hold_mv3_rd0", K_RD, 0, 22'h0);
    expect_v("hold_mv3_rd1", K_RD, 1, 22'h018);
    expect_v("hold_mv3_rd3", K_RD, 3, 22'h0);
    cmd = 3'b101;
    tick();
    cmd = CMD_CHECK;
    tick();
    expect_v("ign101_rd1", K_RD, 1, 22'h018);
    expect_v("ign101_rd3", K_RD, 3, 22'h0);

    // Reset mid-game overrides a command
    cmd = CMD_MOVE;
    reset = 1'b1;
    tick();
    expect_v("midrst_rd1", K_RD, 1, 22'h0);
    expect_v("midrst_rd2", K_RD, 2, 22'h0);
    expect_v("midrst_go", K_GO, 0, 22'h0);
    reset = 1'b0;
    cmd = CMD_CHECK;
    tick();

    repeat (3) tick();
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
